// File: rtl/bit4_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Valid/ready: start is accepted only on an edge where the FSM is in IDLE; done pulses once when results are valid.
module bit4_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH:0]   r_prem;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_prem_next;
    logic [WIDTH-1:0] w_work_next;
    logic             w_last;

    // r_work shifts dividend bits out of its MSB while quotient bits enter at its LSB.
    always_comb begin
        w_shift     = (r_prem << 1) | (WIDTH+1)'(r_work[WIDTH-1]);
        w_ge        = (w_shift >= {1'b0, r_divisor});
        w_prem_next = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
        w_work_next = (r_work << 1) | WIDTH'(w_ge);
        w_last      = (r_count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_divisor   <= '0;
            r_work      <= '0;
            r_prem      <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_divisor   <= divisor;
                        r_work      <= dividend;
                        r_prem      <= '0;
                        r_count     <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            busy    <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_prem  <= w_prem_next;
                    r_work  <= w_work_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        quotient  <= w_work_next;
                        remainder <= w_prem_next[WIDTH-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bit4_divider.sv
// Self-checking bench for bit4_divider: directed corner cases, exhaustive back-to-back sweep, random ops.
module tb_bit4_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W:0] exp_q[$];
    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;

    bit4_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {div_by_zero, quotient, remainder} from plain integer arithmetic.
    function automatic logic [2*W:0] model(input int a, input int b);
        if (b == 0) return {1'b1, W'((1 << W) - 1), W'(a)};
        return {1'b0, W'(a / b), W'(a % b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        prev_q = '0;
        prev_r = '0;
    endtask

    // Issues one op from IDLE, scrambles inputs while it runs, and returns in the first IDLE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W:0] e;
        int k;
        int busy_cnt;
        bit stable;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        tick();
        start    = 1'b0;
        k        = 0;
        busy_cnt = 0;
        stable   = 1'b1;
        while (done !== 1'b1 && k < 3 * W) begin
            if (busy === 1'b1) busy_cnt++;
            if (quotient !== prev_q || remainder !== prev_r) stable = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            start    = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        e = exp_q.pop_front();
        check($sformatf("latency %0d/%0d", a, b), k, (b == 0) ? 0 : W);
        check($sformatf("busy_cycles %0d/%0d", a, b), busy_cnt, (b == 0) ? 0 : W);
        check($sformatf("quotient %0d/%0d", a, b), quotient, e[2*W-1:W]);
        check($sformatf("remainder %0d/%0d", a, b), remainder, e[W-1:0]);
        check($sformatf("div_by_zero %0d/%0d", a, b), div_by_zero, e[2*W]);
        check($sformatf("hold_during_calc %0d/%0d", a, b), stable, 1);
        start = 1'b0;
        tick();
        check($sformatf("done_single_pulse %0d/%0d", a, b), done, 0);
        prev_q = e[2*W-1:W];
        prev_r = e[W-1:0];
    endtask

    initial begin
        int done_cnt;
        logic [W-1:0] cq;
        logic [W-1:0] cr;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        tick();
        reset  = 1'b0;
        prev_q = '0;
        prev_r = '0;
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", div_by_zero, 0);
        check("reset_state", dbg_state, 0);

        run_op(4'd9, 4'd2);
        run_op(4'd15, 4'd15);
        run_op(4'd5, 4'd12);
        run_op(4'd15, 4'd1);
        run_op(4'd7, 4'd0);

        // start pulsed mid-CALC must not disturb the running op.
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dividend = 4'd15;
        divisor  = 4'd1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        done_cnt = 0;
        cq       = '0;
        cr       = '0;
        for (int i = 0; i < 2 * W; i++) begin
            if (done === 1'b1) begin
                done_cnt++;
                cq = quotient;
                cr = remainder;
            end
            tick();
        end
        check("ignore_start_done_count", done_cnt, 1);
        check("ignore_start_quotient", cq, 4);
        check("ignore_start_remainder", cr, 1);
        prev_q = 4'd4;
        prev_r = 4'd1;

        // Reset on the second CALC cycle abandons the op.
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midcalc_reset_quotient", quotient, 0);
        check("midcalc_reset_remainder", remainder, 0);
        check("midcalc_reset_busy", busy, 0);
        check("midcalc_reset_done", done, 0);
        check("midcalc_reset_dbz", div_by_zero, 0);
        done_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
            tick();
        end
        check("midcalc_reset_quiet", done_cnt, 0);
        prev_q = '0;
        prev_r = '0;
        run_op(4'd6, 4'd3);

        // Reset wins over start on the same edge.
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("reset_priority_busy", busy, 0);
        check("reset_priority_state", dbg_state, 0);
        tick();
        check("reset_priority_done", done, 0);
        prev_q = '0;
        prev_r = '0;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(W'(a), W'(b));
            end
        end

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
                tick();
            end
            run_op(W'($urandom), W'($urandom_range(0, 15)));
        end

        do_reset();
        check("final_reset_quotient", quotient, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
